// File: rtl/servo_pkg.sv
// Shared constants, position type and FSM encoding for the multi-channel servo PWM scheduler.
package servo_pkg;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int unsigned NUM_CH_DEF    = 4;
  localparam int unsigned SLOT_CLKS_DEF = 250_000;
  localparam int unsigned MIN_PULSE_DEF = 50_000;
  localparam int unsigned POS_MAX_DEF   = 50_000;
  localparam int unsigned STEP_DEF      = 500;
  localparam int unsigned RST_POS_DEF   = 25_000;
  localparam int unsigned POS_W         = 17;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_UPD  = 2'd2
  } state_e;

endpackage

// File: rtl/servo_slew.sv
// Rate-limited step of one channel's current position toward its target.
module servo_slew
  import servo_pkg::*;
#(
  parameter int unsigned STEP = STEP_DEF
) (
  input  pos_t cur_i,
  input  pos_t tgt_i,
  output pos_t nxt_o
);

  localparam logic [POS_W:0] STEP_X = (POS_W+1)'(STEP);

  logic [POS_W:0] up_x;
  logic [POS_W:0] dn_x;
  logic [POS_W:0] tgt_x;

  // One extra bit so an overshoot above the target or an underflow below zero is visible.
  always_comb begin
    tgt_x = {1'b0, tgt_i};
    up_x  = {1'b0, cur_i} + STEP_X;
    dn_x  = {1'b0, cur_i} - STEP_X;
    nxt_o = cur_i;
    if (cur_i < tgt_i) begin
      nxt_o = (up_x > tgt_x) ? tgt_i : up_x[POS_W-1:0];
    end else if (cur_i > tgt_i) begin
      nxt_o = (dn_x[POS_W] || (dn_x < tgt_x)) ? tgt_i : dn_x[POS_W-1:0];
    end
  end

endmodule

// File: rtl/servo_scheduler.sv
// Time-multiplexed servo PWM: one slot per channel per frame, positions slewed in a short
// update window at the end of the last slot so pulse widths only change on frame boundaries.
module servo_scheduler
  import servo_pkg::*;
#(
  parameter int unsigned NUM_CH    = NUM_CH_DEF,
  parameter int unsigned SLOT_CLKS = SLOT_CLKS_DEF,
  parameter int unsigned MIN_PULSE = MIN_PULSE_DEF,
  parameter int unsigned POS_MAX   = POS_MAX_DEF,
  parameter int unsigned STEP      = STEP_DEF,
  parameter int unsigned RST_POS   = RST_POS_DEF
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [1:0]        wr_ch,
  input  logic [POS_W-1:0]  wr_pos,
  output logic [NUM_CH-1:0] servo,
  output logic [NUM_CH-1:0] at_target,
  output logic              frame_tick
);

  localparam int unsigned CNT_W  = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
  localparam int unsigned SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SLOT_CLKS - 1);
  localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(SLOT_CLKS - NUM_CH - 1);
  localparam logic [CNT_W-1:0]  CNT_UPD0  = CNT_W'(SLOT_CLKS - NUM_CH);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);

  function automatic pos_t clamp_pos(input pos_t p);
    return (32'(p) > POS_MAX) ? POS_W'(POS_MAX) : p;
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  pos_t                cur_q [NUM_CH];
  pos_t                cur_d [NUM_CH];
  pos_t                tgt_q [NUM_CH];
  pos_t                tgt_d [NUM_CH];
  logic [NUM_CH-1:0]   servo_q, servo_d;
  logic [NUM_CH-1:0]   at_tgt_q, at_tgt_d;
  logic                tick_q, tick_d;
  logic                rdy_q, rdy_d;
  logic [SLOT_W-1:0]   upd_idx;
  pos_t                slew_nxt;
  logic                run;
  logic                wr_acc;

  assign run     = enable && (state_q != ST_IDLE);
  assign upd_idx = SLOT_W'(cnt_q - CNT_UPD0);
  assign wr_acc  = wr_valid && rdy_q;

  servo_slew #(.STEP(STEP)) u_slew (
    .cur_i (cur_q[upd_idx]),
    .tgt_i (tgt_q[upd_idx]),
    .nxt_o (slew_nxt)
  );

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN:  if (slot_q == SLOT_LAST && cnt_q == CNT_PRE) state_d = ST_UPD;
        ST_UPD:  if (cnt_q == CNT_LAST) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end

    cnt_d  = cnt_q;
    slot_d = slot_q;
    if (!run) begin
      cnt_d  = '0;
      slot_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Writes and slew never collide: wr_ready is low for the whole update window.
  always_comb begin
    cur_d = cur_q;
    tgt_d = tgt_q;
    if (state_q == ST_UPD) cur_d[upd_idx] = slew_nxt;
    if (wr_acc && (32'(wr_ch) < NUM_CH)) tgt_d[wr_ch] = clamp_pos(wr_pos);

    servo_d  = '0;
    at_tgt_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      servo_d[k]  = run && (slot_q == SLOT_W'(k)) &&
                    (32'(cnt_q) < MIN_PULSE + 32'(cur_q[k]));
      at_tgt_d[k] = (cur_q[k] == tgt_q[k]);
    end
    tick_d = run && (slot_q == SLOT_LAST) && (cnt_q == CNT_LAST);
    rdy_d  = (state_d != ST_UPD);
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      slot_q   <= '0;
      servo_q  <= '0;
      at_tgt_q <= '1;
      tick_q   <= 1'b0;
      rdy_q    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        cur_q[k] <= POS_W'(RST_POS);
        tgt_q[k] <= POS_W'(RST_POS);
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      servo_q  <= servo_d;
      at_tgt_q <= at_tgt_d;
      tick_q   <= tick_d;
      rdy_q    <= rdy_d;
      cur_q    <= cur_d;
      tgt_q    <= tgt_d;
    end
  end

  assign servo      = servo_q;
  assign at_target  = at_tgt_q;
  assign frame_tick = tick_q;
  assign wr_ready   = rdy_q;

endmodule

// File: tb/tb_servo_scheduler.sv
// Bench for servo_scheduler with a shortened frame; positions modelled per frame with plain arithmetic.
module tb_servo_scheduler;

  localparam int NCH   = 4;
  localparam int SLOT  = 100;
  localparam int MINP  = 20;
  localparam int PMAX  = 40;
  localparam int STP   = 6;
  localparam int RPOS  = 20;
  localparam int FRAME = NCH * SLOT;

  logic           mclk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic           wr_valid = 1'b0;
  logic           wr_ready;
  logic [1:0]     wr_ch = 2'd0;
  logic [16:0]    wr_pos = 17'd0;
  logic [NCH-1:0] servo;
  logic [NCH-1:0] at_target;
  logic           frame_tick;

  int checks = 0;
  int errors = 0;
  int cur_m [NCH];
  int tgt_m [NCH];
  int last_w [NCH];

  always #5 mclk = ~mclk;

  servo_scheduler #(
    .NUM_CH(NCH), .SLOT_CLKS(SLOT), .MIN_PULSE(MINP),
    .POS_MAX(PMAX), .STEP(STP), .RST_POS(RPOS)
  ) dut (
    .mclk(mclk), .rst_n(rst_n), .enable(enable),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_pos(wr_pos),
    .servo(servo), .at_target(at_target), .frame_tick(frame_tick)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge mclk);
    #1;
  endtask

  function automatic int slew_m(input int c, input int t);
    if (c < t) return (c + STP > t) ? t : c + STP;
    if (c > t) return (c - STP < t) ? t : c - STP;
    return c;
  endfunction

  function automatic logic [NCH-1:0] at_m();
    logic [NCH-1:0] r;
    for (int k = 0; k < NCH; k++) r[k] = (cur_m[k] == tgt_m[k]);
    return r;
  endfunction

  task automatic frame_end_m;
    for (int k = 0; k < NCH; k++) cur_m[k] = slew_m(cur_m[k], tgt_m[k]);
  endtask

  task automatic write_tgt(input int ch, input int pos);
    wr_ch    = ch[1:0];
    wr_pos   = pos[16:0];
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tgt_m[ch] = (pos > PMAX) ? PMAX : pos;
  endtask

  // Entered on the sample just before a frame's first cycle; leaves on the same phase of a later frame.
  task automatic measure_frames(input int nf);
    for (int f = 0; f < nf; f++) begin
      int w [NCH];
      int st [NCH];
      int tp, nt, multi;
      tp = -1; nt = 0; multi = 0;
      for (int k = 0; k < NCH; k++) begin w[k] = 0; st[k] = -1; end
      for (int j = 0; j < FRAME; j++) begin
        tick();
        if (j == 0) begin
          checks++;
          if (at_target !== at_m()) begin
            errors++;
            $display("FAIL at_target_frame: got %b expected %b", at_target, at_m());
          end
        end
        for (int k = 0; k < NCH; k++) begin
          if (servo[k] === 1'b1) begin
            w[k]++;
            if (st[k] < 0) st[k] = j;
          end
        end
        if ($countones(servo) > 1) multi++;
        if (frame_tick === 1'b1) begin
          nt++;
          if (tp < 0) tp = j;
        end
      end
      for (int k = 0; k < NCH; k++) begin
        checks++;
        if (w[k] != MINP + cur_m[k]) begin
          errors++;
          $display("FAIL pulse_width ch%0d: got %0d expected %0d", k, w[k], MINP + cur_m[k]);
        end
        checks++;
        if (st[k] != k * SLOT) begin
          errors++;
          $display("FAIL pulse_start ch%0d: got %0d expected %0d", k, st[k], k * SLOT);
        end
        last_w[k] = w[k];
      end
      checks++;
      if (tp != FRAME - 1 || nt != 1) begin
        errors++;
        $display("FAIL frame_tick: got pos %0d count %0d expected pos %0d count 1", tp, nt, FRAME - 1);
      end
      checks++;
      if (multi != 0) begin
        errors++;
        $display("FAIL servo_onehot: got %0d overlapping cycles expected 0", multi);
      end
      frame_end_m();
    end
  endtask

  task automatic wait_frame_tick(input int budget);
    int n;
    n = 0;
    tick();
    while (frame_tick !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL frame_tick_wait: got no tick in %0d cycles expected one", budget);
    end else begin
      frame_end_m();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0;
    repeat (3) tick();
    checks++;
    if (servo !== '0 || frame_tick !== 1'b0 || wr_ready !== 1'b0 || at_target !== 4'b1111) begin
      errors++;
      $display("FAIL reset_outputs: got servo=%b tick=%b rdy=%b at=%b expected 0 0 0 1111",
               servo, frame_tick, wr_ready, at_target);
    end
    @(negedge mclk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (wr_ready !== 1'b1 || servo !== '0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b servo=%b expected 1 0000", wr_ready, servo);
    end
  endtask

  task automatic test_basic;
    enable = 1'b1;
    tick();
    measure_frames(2);
    enable = 1'b0;
    repeat (2) tick();
    write_tgt(2, PMAX);
    enable = 1'b1;
    tick();
    measure_frames(5);
    checks++;
    if (last_w[2] != MINP + PMAX || at_target[2] !== 1'b1) begin
      errors++;
      $display("FAIL ramp_ch2: got width %0d at=%b expected %0d 1", last_w[2], at_target[2], MINP + PMAX);
    end
  endtask

  task automatic test_clamp;
    int c1;
    enable = 1'b0;
    repeat (2) tick();
    write_tgt(0, PMAX + 20);
    c1 = cur_m[1];
    write_tgt(1, (c1 >= 4) ? c1 - 4 : c1 + 4);
    tick();
    enable = 1'b1;
    tick();
    measure_frames(1);
    checks++;
    if (at_target[1] !== 1'b1) begin
      errors++;
      $display("FAIL short_step_ch1: got at_target %b expected 1", at_target[1]);
    end
    measure_frames(4);
    checks++;
    if (last_w[0] != MINP + PMAX || at_target[0] !== 1'b1) begin
      errors++;
      $display("FAIL clamp_ch0: got width %0d at=%b expected %0d 1", last_w[0], at_target[0], MINP + PMAX);
    end
  endtask

  task automatic test_back_to_back;
    int n, lows, ch, pos;
    n = 0;
    tick(); n++;
    while (wr_ready === 1'b1 && n < FRAME + 10) begin tick(); n++; end
    checks++;
    if (n != FRAME - NCH) begin
      errors++;
      $display("FAIL ready_fall_pos: got %0d expected %0d", n, FRAME - NCH);
    end
    ch  = $urandom_range(0, NCH - 1);
    pos = (cur_m[ch] >= PMAX / 2) ? cur_m[ch] - 7 - $urandom_range(0, 5)
                                  : cur_m[ch] + 7 + $urandom_range(0, 5);
    wr_ch = ch[1:0]; wr_pos = pos[16:0]; wr_valid = 1'b1;
    lows = 1;
    tick();
    while (wr_ready === 1'b0 && lows < 20) begin lows++; tick(); end
    checks++;
    if (lows != NCH) begin
      errors++;
      $display("FAIL ready_low_len: got %0d expected %0d", lows, NCH);
    end
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL ready_rise_tick: got %b expected 1", frame_tick);
    end
    frame_end_m();
    tick();
    wr_valid = 1'b0;
    tgt_m[ch] = pos;
    tick();
    checks++;
    if (at_target !== at_m() || at_target[ch] !== 1'b0) begin
      errors++;
      $display("FAIL held_write_accept: got %b expected %b", at_target, at_m());
    end
    wait_frame_tick(FRAME + 10);
    measure_frames(3);
  endtask

  task automatic test_enable_drop;
    repeat (SLOT + 6) tick();
    checks++;
    if (servo !== 4'b0010) begin
      errors++;
      $display("FAIL mid_ch1_pulse: got %b expected 0010", servo);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (servo !== '0) begin
      errors++;
      $display("FAIL disable_servo: got %b expected 0000", servo);
    end
    repeat (5) tick();
    checks++;
    if (servo !== '0 || wr_ready !== 1'b1 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs: got servo=%b rdy=%b tick=%b expected 0000 1 0", servo, wr_ready, frame_tick);
    end
    enable = 1'b1;
    tick();
    measure_frames(1);
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      int nw;
      enable = 1'b0;
      repeat (2) tick();
      nw = $urandom_range(1, 3);
      for (int i = 0; i < nw; i++) write_tgt($urandom_range(0, NCH - 1), $urandom_range(0, PMAX + 20));
      tick();
      checks++;
      if (at_target !== at_m()) begin
        errors++;
        $display("FAIL random_at_target: got %b expected %b", at_target, at_m());
      end
      enable = 1'b1;
      tick();
      measure_frames($urandom_range(1, 3));
    end
  endtask

  task automatic test_async_reset;
    enable = 1'b0;
    repeat (2) tick();
    enable = 1'b1;
    tick();
    repeat (6) tick();
    checks++;
    if (servo !== 4'b0001) begin
      errors++;
      $display("FAIL mid_ch0_pulse: got %b expected 0001", servo);
    end
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (servo !== '0 || wr_ready !== 1'b0 || at_target !== 4'b1111) begin
      errors++;
      $display("FAIL async_reset: got servo=%b rdy=%b at=%b expected 0000 0 1111", servo, wr_ready, at_target);
    end
    for (int k = 0; k < NCH; k++) begin cur_m[k] = RPOS; tgt_m[k] = RPOS; end
    @(negedge mclk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: got %b expected 1", wr_ready);
    end
    measure_frames(2);
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) begin cur_m[k] = RPOS; tgt_m[k] = RPOS; end
    test_reset();
    test_basic();
    test_clamp();
    test_back_to_back();
    test_enable_drop();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
